// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared opcodes, FSM states and width helpers for processor_core
// Contents: opcode constants, state_t encoding, instr_w/pc_w width derivation, writes_reg predicate.
package processor_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_EQ  = 3'b110;
  localparam logic [2:0] OP_BR  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Instruction is [opcode(3) | C | A | B], each register field ra_w bits.
  function automatic int instr_w(input int ra_w);
    return 3 + 3 * ra_w;
  endfunction

  // Program counter spans the concatenated A|B fields so any branch target is reachable.
  function automatic int pc_w(input int ra_w);
    return 2 * ra_w;
  endfunction

  function automatic logic writes_reg(input logic [2:0] op);
    return (op != OP_NOP) && (op != OP_BR);
  endfunction

endpackage

// File: rtl/processor_if.sv
// rtl/processor_if.sv - instruction memory bus between processor_core and a synchronous ROM/RAM
// Signals: imem_addr (PC_W, to memory), imem_en (read strobe, to memory),
//          imem_data (INSTR_W, from memory, valid the cycle after imem_en).
// Modports: master = core side, slave = memory side.
interface processor_if #(
  parameter int RA_W = 3
);
  localparam int PC_W    = 2 * RA_W;
  localparam int INSTR_W = 3 + 3 * RA_W;

  logic [PC_W-1:0]    imem_addr;
  logic               imem_en;
  logic [INSTR_W-1:0] imem_data;

  modport master (
    output imem_addr,
    output imem_en,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    input  imem_en,
    output imem_data
  );

endinterface

// File: rtl/processor_regfile.sv
// rtl/processor_regfile.sv - gp_regfile: 2**RA_W x DATA_W register file, async reset to zero
// Ports: clk, rst (async, active high); we/waddr/wdata synchronous write;
//        raddr_a/rdata_a and raddr_b/rdata_b combinational operand reads;
//        dbg_addr/dbg_data combinational debug read.
module gp_regfile #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [RA_W-1:0]   raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 2 ** RA_W;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads are not bypassed: a write lands at the clock edge, so a read in the
  // same cycle as the write sees the old value.
  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/processor_core.sv
// rtl/processor_core.sv - multi-cycle (FETCH/DECODE/EXEC/WB) processor with PC, flags and debug read
// Ports: clk, rst (async, active high); run (level start/continue);
//        imem (processor_if.master: imem_addr = pc, imem_en in FETCH, imem_data one cycle later);
//        pc; retire (pulse in WB); branch_flag, co_flag, eq_flag (sticky, updated in WB);
//        halted (state is IDLE); dbg_addr/dbg_data (combinational register read).
module processor_core
  import processor_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RA_W   = 3,
  localparam int PC_W    = pc_w(RA_W),
  localparam int INSTR_W = instr_w(RA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  processor_if.master       imem,
  output logic [PC_W-1:0]   pc,
  output logic              retire,
  output logic              branch_flag,
  output logic              co_flag,
  output logic              eq_flag,
  output logic              halted,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t state, state_next;

  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic [DATA_W-1:0]  res_q;
  logic               co_q;
  logic               eq_q;
  logic               br_taken;

  logic               imem_en;
  logic [2:0]         ir_op;
  logic [RA_W-1:0]    ir_c;
  logic [RA_W-1:0]    in_a;
  logic [RA_W-1:0]    in_b;
  logic [DATA_W-1:0]  rd_a;
  logic [DATA_W-1:0]  rd_b;
  logic               rf_we;

  logic [DATA_W-1:0]  alu_res;
  logic               alu_co;
  logic               alu_eq;

  // Operand addresses come straight off the memory bus during DECODE so the
  // operands are captured in the same edge as the instruction word.
  assign ir_op = ir[INSTR_W-1 -: 3];
  assign ir_c  = ir[3*RA_W-1 -: RA_W];
  assign in_a  = imem.imem_data[2*RA_W-1 -: RA_W];
  assign in_b  = imem.imem_data[RA_W-1:0];

  assign imem.imem_addr = pc;
  assign imem.imem_en   = imem_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    imem_en    = 1'b0;
    retire     = 1'b0;
    halted     = 1'b0;
    case (state)
      S_IDLE: begin
        halted = 1'b1;
        if (run) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_en    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        state_next = S_EXEC;
      end
      S_EXEC: begin
        state_next = S_WB;
      end
      S_WB: begin
        retire     = 1'b1;
        state_next = run ? S_FETCH : S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_co  = 1'b0;
    alu_eq  = (op_a == op_b);
    case (ir_op)
      OP_ADD:  {alu_co, alu_res} = {1'b0, op_a} + {1'b0, op_b};
      // The extra top bit of the widened difference is the unsigned borrow.
      OP_SUB:  {alu_co, alu_res} = {1'b0, op_a} - {1'b0, op_b};
      OP_AND:  alu_res = op_a & op_b;
      OP_NOT:  alu_res = ~op_a;
      OP_OR:   alu_res = op_a | op_b;
      OP_EQ:   alu_res = DATA_W'(alu_eq);
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir          <= '0;
      op_a        <= '0;
      op_b        <= '0;
      res_q       <= '0;
      co_q        <= 1'b0;
      eq_q        <= 1'b0;
      br_taken    <= 1'b0;
      pc          <= '0;
      branch_flag <= 1'b0;
      co_flag     <= 1'b0;
      eq_flag     <= 1'b0;
    end else begin
      case (state)
        S_DECODE: begin
          ir   <= imem.imem_data;
          op_a <= rd_a;
          op_b <= rd_b;
        end
        S_EXEC: begin
          res_q    <= alu_res;
          co_q     <= alu_co;
          eq_q     <= alu_eq;
          // Decided on the eq_flag that existed before this instruction.
          br_taken <= (ir_op == OP_BR) && eq_flag;
        end
        S_WB: begin
          pc          <= br_taken ? ir[PC_W-1:0] : pc + PC_W'(1);
          branch_flag <= br_taken;
          if ((ir_op == OP_ADD) || (ir_op == OP_SUB)) begin
            co_flag <= co_q;
          end
          if (ir_op == OP_EQ) begin
            eq_flag <= eq_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rf_we = (state == S_WB) && writes_reg(ir_op);

  gp_regfile #(
    .DATA_W (DATA_W),
    .RA_W   (RA_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (ir_c),
    .wdata    (res_q),
    .raddr_a  (in_a),
    .rdata_a  (rd_a),
    .raddr_b  (in_b),
    .rdata_b  (rd_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule
